abscmd_encoder: RTL and testbench

ABSCMD_ENCODER -- requirements
Module: abscmd_encoder

---
 rtl/abscmd_encoder_pkg.sv | 124 ++++++++++++
 rtl/abscmd_encoder.sv | 152 +++++++++++++++
 tb/tb_abscmd_encoder.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/abscmd_encoder_pkg.sv
// Shared types, constants and instruction-word builders for the abstract-command encoder.
// Every word the encoder emits is built by the functions at the bottom of this package.
package abscmd_encoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_XFER         = 3'd1,
        ST_XFER_WAIT    = 3'd2,
        ST_PROGBUF      = 3'd3,
        ST_PROGBUF_WAIT = 3'd4,
        ST_RESP         = 3'd5
    } state_e;

    localparam logic [6:0]  OPC_SYSTEM = 7'h73;
    localparam logic [2:0]  F3_CSRRW   = 3'b001;
    localparam logic [2:0]  F3_CSRRS   = 3'b010;
    localparam logic [4:0]  REG_X0     = 5'd0;
    localparam logic [4:0]  REG_X1     = 5'd1;

    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] FMV_D_X      = 32'hF200_8053;
    localparam logic [31:0] FMV_W_X      = 32'hF000_8053;
    localparam logic [31:0] FMV_X_D      = 32'hE200_00D3;
    localparam logic [31:0] FMV_X_W      = 32'hE000_00D3;

    localparam logic [15:0] REGNO_FIRST = 16'h1000;
    localparam logic [15:0] REGNO_LAST  = 16'h103F;
    localparam logic [3:0]  PB_LAST_IDX = 4'd15;

    localparam logic [2:0]  CMDERR_NONE          = 3'd0;
    localparam logic [2:0]  CMDERR_NOT_SUPPORTED = 3'd2;
    localparam logic [2:0]  CMDERR_EXCEPTION     = 3'd3;

    typedef struct packed {
        state_e        state;
        logic [15:0]   regno;
        logic          write;
        logic          postexec;
        logic [2:0]    aarsize;
        logic [511:0]  progbuf;
        logic [1:0]    step;
        logic [3:0]    pb_idx;
        logic          instr_valid;
        logic [31:0]   instr;
        logic          progbuf_ena;
        logic          resp_valid;
        logic [2:0]    cmderr;
    } regs_t;

    localparam regs_t REGS_RESET = '{
        state:       ST_IDLE,
        regno:       16'h0,
        write:       1'b0,
        postexec:    1'b0,
        aarsize:     3'h0,
        progbuf:     512'h0,
        step:        2'h0,
        pb_idx:      4'h0,
        instr_valid: 1'b0,
        instr:       32'h0,
        progbuf_ena: 1'b0,
        resp_valid:  1'b0,
        cmderr:      3'h0
    };

    function automatic logic [31:0] csr_instr(input logic [11:0] csr, input logic [4:0] rs1,
                                              input logic [2:0] f3, input logic [4:0] rd);
        return {csr, rs1, f3, rd, OPC_SYSTEM};
    endfunction

    // csrrw x0, csr, rs1 : push a GPR into a CSR
    function automatic logic [31:0] csrrw_from(input logic [11:0] csr, input logic [4:0] rs1);
        return csr_instr(csr, rs1, F3_CSRRW, REG_X0);
    endfunction

    // csrrs rd, csr, x0 : pull a CSR into a GPR
    function automatic logic [31:0] csrrs_to(input logic [4:0] rd, input logic [11:0] csr);
        return csr_instr(csr, REG_X0, F3_CSRRS, rd);
    endfunction

    function automatic logic [31:0] fmv_to_fpr(input logic [4:0] fd, input logic w32);
        return (w32 ? FMV_W_X : FMV_D_X) | {20'h0, fd, 7'h0};
    endfunction

    function automatic logic [31:0] fmv_to_gpr(input logic [4:0] fs, input logic w32);
        return (w32 ? FMV_X_W : FMV_X_D) | {12'h0, fs, 15'h0};
    endfunction

    function automatic logic regno_supported(input logic [15:0] regno, input logic [2:0] aarsize);
        return (regno >= REGNO_FIRST) && (regno <= REGNO_LAST) &&
               ((aarsize == 3'd2) || (aarsize == 3'd3));
    endfunction

    // GPR transfers are one word; FPR transfers borrow x1 and take four
    function automatic logic is_last_step(input logic [15:0] regno, input logic [1:0] step);
        return regno[5] ? (step == 2'd3) : 1'b1;
    endfunction

    function automatic logic [31:0] xfer_word(input logic [15:0] regno, input logic write,
                                              input logic [2:0] aarsize, input logic [1:0] step,
                                              input logic [11:0] csr_data, input logic [11:0] csr_save);
        logic [4:0]  n;
        logic        w32;
        logic [31:0] word;
        n   = regno[4:0];
        w32 = (aarsize == 3'd2);
        if (!regno[5]) begin
            word = write ? csrrs_to(n, csr_data) : csrrw_from(csr_data, n);
        end else begin
            case (step)
                2'd0:    word = csrrw_from(csr_save, REG_X1);
                2'd1:    word = write ? csrrs_to(REG_X1, csr_data) : fmv_to_gpr(n, w32);
                2'd2:    word = write ? fmv_to_fpr(n, w32) : csrrw_from(csr_data, REG_X1);
                default: word = csrrs_to(REG_X1, csr_save);
            endcase
        end
        return word;
    endfunction

    function automatic logic [31:0] progbuf_word(input logic [511:0] pb, input logic [3:0] idx);
        return pb[32 * int'(idx) +: 32];
    endfunction

endpackage

// File: rtl/abscmd_encoder.sv
// Turns a debug abstract command into a stream of RISC-V instruction words, optionally
// followed by the program buffer, and reports completion with a one-cycle response.
//
// state           | meaning
// ----------------+--------------------------------------------------------------
// ST_IDLE         | ready for a command
// ST_XFER         | transfer word presented, waiting for i_instr_ready
// ST_XFER_WAIT    | transfer word accepted, waiting for retire or exception
// ST_PROGBUF      | program-buffer word presented, waiting for i_instr_ready
// ST_PROGBUF_WAIT | program-buffer word accepted, waiting for retire or exception
// ST_RESP         | one-cycle completion pulse with cmderr
module abscmd_encoder
    import abscmd_encoder_pkg::*;
#(
    parameter logic [11:0] CSR_DSCRATCH0 = 12'h7B2,
    parameter logic [11:0] CSR_DSCRATCH1 = 12'h7B3
) (
    input  logic          i_clk,
    input  logic          i_nrst,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic [15:0]   i_regno,
    input  logic          i_write,
    input  logic          i_transfer,
    input  logic          i_postexec,
    input  logic [2:0]    i_aarsize,
    input  logic [511:0]  i_progbuf,
    output logic          o_instr_valid,
    input  logic          i_instr_ready,
    output logic [31:0]   o_instr,
    output logic          o_progbuf_ena,
    input  logic          i_instr_retired,
    input  logic          i_instr_exception,
    output logic          o_resp_valid,
    output logic [2:0]    o_cmderr
);

    regs_t r;

    assign o_cmd_ready   = (r.state == ST_IDLE);
    assign o_instr_valid = r.instr_valid;
    assign o_instr       = r.instr;
    assign o_progbuf_ena = r.progbuf_ena;
    assign o_resp_valid  = r.resp_valid;
    assign o_cmderr      = r.cmderr;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r <= REGS_RESET;
        end else begin
            case (r.state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        r.regno       <= i_regno;
                        r.write       <= i_write;
                        r.postexec    <= i_postexec;
                        r.aarsize     <= i_aarsize;
                        r.progbuf     <= i_progbuf;
                        r.step        <= 2'd0;
                        r.pb_idx      <= 4'd0;
                        r.cmderr      <= CMDERR_NONE;
                        r.progbuf_ena <= 1'b0;
                        if (i_transfer) begin
                            if (!regno_supported(i_regno, i_aarsize)) begin
                                r.cmderr     <= CMDERR_NOT_SUPPORTED;
                                r.resp_valid <= 1'b1;
                                r.state      <= ST_RESP;
                            end else begin
                                r.instr       <= xfer_word(i_regno, i_write, i_aarsize, 2'd0,
                                                           CSR_DSCRATCH0, CSR_DSCRATCH1);
                                r.instr_valid <= 1'b1;
                                r.state       <= ST_XFER;
                            end
                        end else if (i_postexec) begin
                            r.instr       <= progbuf_word(i_progbuf, 4'd0);
                            r.instr_valid <= 1'b1;
                            r.progbuf_ena <= 1'b1;
                            r.state       <= ST_PROGBUF;
                        end else begin
                            r.resp_valid <= 1'b1;
                            r.state      <= ST_RESP;
                        end
                    end
                end

                ST_XFER, ST_PROGBUF: begin
                    if (i_instr_ready) begin
                        r.instr_valid <= 1'b0;
                        r.state       <= (r.state == ST_XFER) ? ST_XFER_WAIT : ST_PROGBUF_WAIT;
                    end
                end

                ST_XFER_WAIT: begin
                    // An exception wins even if the retire pulse arrives in the same cycle
                    if (i_instr_exception) begin
                        r.cmderr     <= CMDERR_EXCEPTION;
                        r.resp_valid <= 1'b1;
                        r.state      <= ST_RESP;
                    end else if (i_instr_retired) begin
                        if (!is_last_step(r.regno, r.step)) begin
                            r.step        <= r.step + 2'd1;
                            r.instr       <= xfer_word(r.regno, r.write, r.aarsize, r.step + 2'd1,
                                                       CSR_DSCRATCH0, CSR_DSCRATCH1);
                            r.instr_valid <= 1'b1;
                            r.state       <= ST_XFER;
                        end else if (r.postexec) begin
                            r.pb_idx      <= 4'd0;
                            r.instr       <= progbuf_word(r.progbuf, 4'd0);
                            r.instr_valid <= 1'b1;
                            r.progbuf_ena <= 1'b1;
                            r.state       <= ST_PROGBUF;
                        end else begin
                            r.resp_valid <= 1'b1;
                            r.state      <= ST_RESP;
                        end
                    end
                end

                ST_PROGBUF_WAIT: begin
                    if (i_instr_exception) begin
                        r.cmderr      <= CMDERR_EXCEPTION;
                        r.resp_valid  <= 1'b1;
                        r.progbuf_ena <= 1'b0;
                        r.state       <= ST_RESP;
                    end else if (i_instr_retired) begin
                        if ((r.instr == INSTR_EBREAK) || (r.pb_idx == PB_LAST_IDX)) begin
                            r.resp_valid  <= 1'b1;
                            r.progbuf_ena <= 1'b0;
                            r.state       <= ST_RESP;
                        end else begin
                            r.pb_idx      <= r.pb_idx + 4'd1;
                            r.instr       <= progbuf_word(r.progbuf, r.pb_idx + 4'd1);
                            r.instr_valid <= 1'b1;
                            r.state       <= ST_PROGBUF;
                        end
                    end
                end

                ST_RESP: begin
                    r.resp_valid  <= 1'b0;
                    r.progbuf_ena <= 1'b0;
                    r.step        <= 2'd0;
                    r.pb_idx      <= 4'd0;
                    r.state       <= ST_IDLE;
                end

                default: r <= REGS_RESET;
            endcase
        end
    end

endmodule

// File: tb/tb_abscmd_encoder.sv
// Self-checking bench for abscmd_encoder: vector table plus hand-written corner sequences,
// with expected instruction words and cmderr values queued before each command is issued.
module tb_abscmd_encoder;

    logic          i_clk = 1'b0;
    logic          i_nrst = 1'b0;
    logic          i_cmd_valid = 1'b0;
    logic          o_cmd_ready;
    logic [15:0]   i_regno = '0;
    logic          i_write = 1'b0;
    logic          i_transfer = 1'b0;
    logic          i_postexec = 1'b0;
    logic [2:0]    i_aarsize = '0;
    logic [511:0]  i_progbuf = '0;
    logic          o_instr_valid;
    logic          i_instr_ready = 1'b0;
    logic [31:0]   o_instr;
    logic          o_progbuf_ena;
    logic          i_instr_retired = 1'b0;
    logic          i_instr_exception = 1'b0;
    logic          o_resp_valid;
    logic [2:0]    o_cmderr;

    abscmd_encoder dut (
        .i_clk(i_clk), .i_nrst(i_nrst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_regno(i_regno), .i_write(i_write), .i_transfer(i_transfer),
        .i_postexec(i_postexec), .i_aarsize(i_aarsize), .i_progbuf(i_progbuf),
        .o_instr_valid(o_instr_valid), .i_instr_ready(i_instr_ready), .o_instr(o_instr),
        .o_progbuf_ena(o_progbuf_ena), .i_instr_retired(i_instr_retired),
        .i_instr_exception(i_instr_exception), .o_resp_valid(o_resp_valid), .o_cmderr(o_cmderr)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;

    logic [32:0] exp_q[$];     // {progbuf_ena, word}
    logic [2:0]  err_q[$];

    typedef struct {
        logic [15:0]       regno;
        logic              write;
        logic              transfer;
        logic              postexec;
        logic [2:0]        aarsize;
        int                stall;
        int                exc;
        logic [2:0]        err;
        int                n;
        logic [3:0]        pbmask;
        logic [3:0][31:0]  w;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [15:0] regno, input logic write, input logic transfer,
                           input logic postexec, input logic [2:0] aarsize, input int stall,
                           input int exc, input logic [2:0] err, input int n, input logic [3:0] pbmask,
                           input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
        vec_t v;
        v.regno = regno; v.write = write; v.transfer = transfer; v.postexec = postexec;
        v.aarsize = aarsize; v.stall = stall; v.exc = exc; v.err = err; v.n = n; v.pbmask = pbmask;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        vecs.push_back(v);
    endtask

    // Runs one command from acceptance to its response pulse, acting as the pipeline.
    task automatic issue(input string tag, input logic [15:0] regno, input logic write,
                         input logic transfer, input logic postexec, input logic [2:0] aarsize,
                         input logic [511:0] pb, input int stall, input int exc, input bit exc_with_ret);
        int cyc;
        int widx;
        int stall_left;
        int busy_ready;
        bit done;
        bit first;
        logic [32:0] e;
        i_regno = regno; i_write = write; i_transfer = transfer; i_postexec = postexec;
        i_aarsize = aarsize; i_progbuf = pb; i_cmd_valid = 1'b1;
        check({tag, "/cmd_ready"}, {63'h0, o_cmd_ready}, 64'h1);
        @(posedge i_clk); #1;
        // Hold a bogus request on the inputs while busy: it must be neither accepted nor latched
        i_regno = 16'h2000; i_write = ~write; i_transfer = 1'b1; i_postexec = ~postexec;
        i_aarsize = 3'd7;
        for (int k = 0; k < 16; k++) i_progbuf[32*k +: 32] = $urandom();
        cyc = 1; widx = 0; stall_left = stall; busy_ready = 0; done = 0; first = 1;
        while (!done && cyc < 400) begin
            if (o_cmd_ready) busy_ready++;
            if (o_resp_valid) begin
                i_cmd_valid = 1'b0;
                if (first) check({tag, "/resp_latency"}, 64'(cyc), 64'd1);
                if (err_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL %s/unexpected_resp actual=cmderr %0d required=no response", tag, o_cmderr);
                end else begin
                    check({tag, "/cmderr"}, {61'h0, o_cmderr}, {61'h0, err_q.pop_front()});
                end
                check({tag, "/words_left"}, 64'(exp_q.size()), 64'd0);
                exp_q.delete();
                done = 1;
            end else if (o_instr_valid) begin
                if (first) check({tag, "/first_word_latency"}, 64'(cyc), 64'd1);
                first = 0;
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL %s/unexpected_word actual=%h required=no word", tag, o_instr);
                    i_instr_ready = 1'b1;
                    @(posedge i_clk); #1; cyc++;
                    i_instr_ready = 1'b0;
                    i_instr_exception = 1'b1;
                    @(posedge i_clk); #1; cyc++;
                    i_instr_exception = 1'b0;
                end else if (stall_left > 0) begin
                    e = exp_q[0];
                    check({tag, "/stall_stable"}, {31'h0, o_instr_valid, o_progbuf_ena, o_instr},
                          {31'h0, 1'b1, e});
                    stall_left--;
                    @(posedge i_clk); #1; cyc++;
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("%s/word%0d", tag, widx), {31'h0, o_progbuf_ena, o_instr}, {31'h0, e});
                    i_instr_ready = 1'b1;
                    @(posedge i_clk); #1; cyc++;
                    i_instr_ready = 1'b0;
                    check($sformatf("%s/valid_drop%0d", tag, widx), {63'h0, o_instr_valid}, 64'h0);
                    @(posedge i_clk); #1; cyc++;
                    if (widx == exc) begin
                        i_instr_exception = 1'b1;
                        i_instr_retired = exc_with_ret;
                    end else begin
                        i_instr_retired = 1'b1;
                    end
                    widx++;
                    @(posedge i_clk); #1; cyc++;
                    i_instr_retired = 1'b0;
                    i_instr_exception = 1'b0;
                end
            end else begin
                @(posedge i_clk); #1; cyc++;
            end
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL %s/timeout actual=no response required=response within 400 cycles", tag);
            i_cmd_valid = 1'b0;
            exp_q.delete();
            err_q.delete();
        end
        check({tag, "/not_ready_while_busy"}, 64'(busy_ready), 64'd0);
        @(posedge i_clk); #1;
        check({tag, "/back_to_idle"}, {62'h0, o_resp_valid, o_cmd_ready}, 64'h1);
    endtask

    logic [511:0] pb_std;
    logic [511:0] pb_nops;
    logic [2:0]   reset_vec_cmderr;
    int           resp_seen;

    initial begin
        pb_std = '0;
        pb_std[31:0]  = 32'h0000_0013;
        pb_std[63:32] = 32'h0010_0073;
        for (int k = 2; k < 16; k++) pb_std[32*k +: 32] = 32'h0000_0013;
        pb_nops = '0;
        for (int k = 0; k < 16; k++) pb_nops[32*k +: 32] = 32'h0000_0013;

        //       regno     wr    xfer  pexec  size  stall exc  err   n  pbmask
        add_vec(16'h1000, 1'b0, 1'b1, 1'b0, 3'd2, 0, -1, 3'd0, 1, 4'b0000,
                32'h7B20_1073, 32'h0, 32'h0, 32'h0);
        add_vec(16'h1005, 1'b0, 1'b1, 1'b0, 3'd3, 0, -1, 3'd0, 1, 4'b0000,
                32'h7B22_9073, 32'h0, 32'h0, 32'h0);
        add_vec(16'h1001, 1'b1, 1'b1, 1'b0, 3'd3, 0, -1, 3'd0, 1, 4'b0000,
                32'h7B20_20F3, 32'h0, 32'h0, 32'h0);
        add_vec(16'h101F, 1'b1, 1'b1, 1'b0, 3'd2, 0, -1, 3'd0, 1, 4'b0000,
                32'h7B20_2FF3, 32'h0, 32'h0, 32'h0);
        add_vec(16'h1022, 1'b1, 1'b1, 1'b0, 3'd3, 3, -1, 3'd0, 4, 4'b0000,
                32'h7B30_9073, 32'h7B20_20F3, 32'hF200_8153, 32'h7B30_20F3);
        add_vec(16'h1023, 1'b1, 1'b1, 1'b0, 3'd2, 0, -1, 3'd0, 4, 4'b0000,
                32'h7B30_9073, 32'h7B20_20F3, 32'hF000_81D3, 32'h7B30_20F3);
        add_vec(16'h1024, 1'b0, 1'b1, 1'b0, 3'd3, 0, -1, 3'd0, 4, 4'b0000,
                32'h7B30_9073, 32'hE202_00D3, 32'h7B20_9073, 32'h7B30_20F3);
        add_vec(16'h103F, 1'b0, 1'b1, 1'b0, 3'd2, 1, -1, 3'd0, 4, 4'b0000,
                32'h7B30_9073, 32'hE00F_80D3, 32'h7B20_9073, 32'h7B30_20F3);
        add_vec(16'h2000, 1'b0, 1'b1, 1'b0, 3'd3, 0, -1, 3'd2, 0, 4'b0000,
                32'h0, 32'h0, 32'h0, 32'h0);
        add_vec(16'h1005, 1'b0, 1'b1, 1'b1, 3'd4, 0, -1, 3'd2, 0, 4'b0000,
                32'h0, 32'h0, 32'h0, 32'h0);
        add_vec(16'h1040, 1'b1, 1'b1, 1'b0, 3'd2, 0, -1, 3'd2, 0, 4'b0000,
                32'h0, 32'h0, 32'h0, 32'h0);
        add_vec(16'h0FFF, 1'b0, 1'b1, 1'b0, 3'd3, 0, -1, 3'd2, 0, 4'b0000,
                32'h0, 32'h0, 32'h0, 32'h0);
        add_vec(16'h2000, 1'b0, 1'b0, 1'b0, 3'd7, 0, -1, 3'd0, 0, 4'b0000,
                32'h0, 32'h0, 32'h0, 32'h0);
        add_vec(16'h0000, 1'b0, 1'b0, 1'b1, 3'd0, 0, -1, 3'd0, 2, 4'b0011,
                32'h0000_0013, 32'h0010_0073, 32'h0, 32'h0);
        add_vec(16'h1001, 1'b1, 1'b1, 1'b1, 3'd2, 0, -1, 3'd0, 3, 4'b0110,
                32'h7B20_20F3, 32'h0000_0013, 32'h0010_0073, 32'h0);
        add_vec(16'h1005, 1'b0, 1'b1, 1'b0, 3'd3, 0, 0, 3'd3, 1, 4'b0000,
                32'h7B22_9073, 32'h0, 32'h0, 32'h0);
        add_vec(16'h0000, 1'b0, 1'b0, 1'b1, 3'd0, 0, 0, 3'd3, 1, 4'b0001,
                32'h0000_0013, 32'h0, 32'h0, 32'h0);

        repeat (3) @(posedge i_clk);
        #1;
        check("reset_outputs", {26'h0, o_cmd_ready, o_instr_valid, o_instr, o_progbuf_ena, o_resp_valid, o_cmderr},
              {26'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3'h0});
        i_nrst = 1'b1;
        @(posedge i_clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            for (int j = 0; j < vecs[i].n; j++) exp_q.push_back({vecs[i].pbmask[j], vecs[i].w[j]});
            err_q.push_back(vecs[i].err);
            issue($sformatf("vec%0d", i), vecs[i].regno, vecs[i].write, vecs[i].transfer,
                  vecs[i].postexec, vecs[i].aarsize, pb_std, vecs[i].stall, vecs[i].exc, 1'b0);
        end

        // FPR write trapping on its second word, with retire and exception in the same cycle
        exp_q.push_back({1'b0, 32'h7B30_9073});
        exp_q.push_back({1'b0, 32'h7B20_20F3});
        err_q.push_back(3'd3);
        issue("fpr_exc_step2", 16'h1022, 1'b1, 1'b1, 1'b0, 3'd3, pb_std, 0, 1, 1'b1);

        // Program buffer without ebreak: all 16 words, then stop without wrapping
        for (int k = 0; k < 16; k++) exp_q.push_back({1'b1, 32'h0000_0013});
        err_q.push_back(3'd0);
        issue("progbuf_full", 16'h0000, 1'b0, 1'b0, 1'b1, 3'd0, pb_nops, 0, -1, 1'b0);

        // Reset while waiting for a transfer word to retire
        i_regno = 16'h1005; i_write = 1'b0; i_transfer = 1'b1; i_postexec = 1'b1;
        i_aarsize = 3'd3; i_progbuf = pb_std; i_cmd_valid = 1'b1;
        @(posedge i_clk); #1;
        i_cmd_valid = 1'b0;
        check("rst_abort/word", {31'h0, o_instr_valid, 32'h0, o_instr}, {31'h0, 1'b1, 32'h0, 32'h7B22_9073});
        i_instr_ready = 1'b1;
        @(posedge i_clk); #1;
        i_instr_ready = 1'b0;
        check("rst_abort/in_wait", {62'h0, o_instr_valid, o_cmd_ready}, 64'h0);
        i_nrst = 1'b0;
        #2;
        check("rst_abort/async", {26'h0, o_cmd_ready, o_instr_valid, o_instr, o_progbuf_ena, o_resp_valid, o_cmderr},
              {26'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3'h0});
        resp_seen = 0;
        repeat (2) begin
            @(posedge i_clk); #1;
            if (o_resp_valid) resp_seen++;
        end
        i_nrst = 1'b1;
        i_instr_retired = 1'b1;
        @(posedge i_clk); #1;
        i_instr_retired = 1'b0;
        if (o_resp_valid) resp_seen++;
        repeat (4) begin
            @(posedge i_clk); #1;
            if (o_resp_valid || o_instr_valid) resp_seen++;
        end
        check("rst_abort/no_resp", 64'(resp_seen), 64'd0);
        reset_vec_cmderr = o_cmderr;
        check("rst_abort/idle", {60'h0, o_cmd_ready, reset_vec_cmderr}, {60'h0, 1'b1, 3'h0});

        exp_q.push_back({1'b0, 32'h7B22_9073});
        err_q.push_back(3'd0);
        issue("after_reset", 16'h1005, 1'b0, 1'b1, 1'b0, 3'd3, pb_std, 0, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
